// File: rtl/fixed_to_float.sv
// Sequential converter from Q1.30 two's-complement fixed point to IEEE-754 single precision.
// Normalizes with a one-bit-per-cycle left shift; mantissa is truncated toward zero.
module fixed_to_float #(
  parameter int unsigned P    = 32,
  parameter int unsigned Frac = 30
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [P-1:0] fixed_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [P-1:0] float_o,
  output logic         zero_o
);

  localparam logic [7:0] ExpInit = 8'(127 + (P - 1) - Frac);

  typedef enum logic [1:0] {StIdle, StAbs, StNorm, StPack} state_e;

  state_e       state_q, state_d;
  logic [P-1:0] op_q, op_d;
  logic [P-1:0] mag_q, mag_d;
  logic [7:0]   exp_q, exp_d;
  logic         sign_q, sign_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         zero_q, zero_d;
  logic [P-1:0] float_q, float_d;

  logic [P-1:0] abs_mag;
  logic [P-1:0] mag_shl;

  // The most negative operand maps to unsigned 2^(P-1), which already has its MSB set.
  assign abs_mag = op_q[P-1] ? ((~op_q) + {{(P-1){1'b0}}, 1'b1}) : op_q;
  assign mag_shl = {mag_q[P-2:0], 1'b0};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_i) state_d = StAbs;
      StAbs: begin
        if (abs_mag == '0 || abs_mag[P-1]) state_d = StPack;
        else                               state_d = StNorm;
      end
      StNorm: if (mag_shl[P-1]) state_d = StPack;
      StPack: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    zero_d  = zero_q;
    float_d = float_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          op_d   = fixed_i;
          busy_d = 1'b1;
        end
      end
      StAbs: begin
        sign_d = op_q[P-1];
        mag_d  = abs_mag;
        exp_d  = ExpInit;
      end
      StNorm: begin
        mag_d = mag_shl;
        exp_d = exp_q - 8'd1;
      end
      StPack: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (mag_q == '0) begin
          float_d = '0;
          zero_d  = 1'b1;
        end else begin
          float_d = {sign_q, exp_q, mag_q[P-2 -: P-9]};
          zero_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q    <= '0;
      mag_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      float_q <= '0;
    end else begin
      op_q    <= op_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
      float_q <= float_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign float_o = float_q;
  assign zero_o  = zero_q;

endmodule

// File: tb/tb_fixed_to_float.sv
// Bench for fixed_to_float: directed vector table, random operands against a value-level
// model, plus reset-abort and handshake sequences.
module tb_fixed_to_float;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] fixed = '0;
  logic        busy, done, zero;
  logic [31:0] flt;

  int checks = 0;
  int failures = 0;

  fixed_to_float #(.P(32), .Frac(30)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .fixed_i (fixed),
    .busy_o  (busy),
    .done_o  (done),
    .float_o (flt),
    .zero_o  (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fx;
    logic [31:0] fl;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Value-level model: |x| = m * 2^-30, float = 1.f * 2^(p-30) with p the leading-one position.
  task automatic ref_model(input logic [31:0] v, output logic [31:0] f, output int lat);
    longint      m;
    int          p;
    logic [31:0] mant;
    logic [7:0]  e;
    m = longint'($signed(v));
    if (m < 0) m = -m;
    if (m == 0) begin
      f   = '0;
      lat = 2;
      return;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (m >= (longint'(1) << i)) p = i;
    e = 8'(127 + p - 30);
    m = m - (longint'(1) << p);
    if (p >= 23) mant = 32'(m >> (p - 23));
    else         mant = 32'(m << (23 - p));
    f   = {v[31], e, mant[22:0]};
    lat = 33 - p;
  endtask

  // Starts one conversion, scrambles FIXED after acceptance, waits (bounded) for DONE.
  task automatic run_conv(input logic [31:0] v, output logic [31:0] f, output logic z,
                          output int edges, output int busy_cycles);
    @(negedge clk);
    fixed = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    fixed = $urandom;
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (busy === 1'b1) busy_cycles++;
    end while (done !== 1'b1 && edges < 40);
    f = flt;
    z = zero;
  endtask

  initial begin
    logic [31:0] f, rf, v;
    logic        z;
    int          edges, bc, rl, pulses;
    logic [31:0] ops[3];

    vecs[0] = '{32'h4000_0000, 32'h3F80_0000, 1'b0, 3};
    vecs[1] = '{32'h2000_0000, 32'h3F00_0000, 1'b0, 4};
    vecs[2] = '{32'hC000_0000, 32'hBF80_0000, 1'b0, 3};
    vecs[3] = '{32'h8000_0000, 32'hC000_0000, 1'b0, 2};
    vecs[4] = '{32'h0000_0001, 32'h3080_0000, 1'b0, 33};
    vecs[5] = '{32'hFFFF_FFFF, 32'hB080_0000, 1'b0, 33};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 2};
    vecs[7] = '{32'h5555_5555, 32'h3FAA_AAAA, 1'b0, 3};
    vecs[8] = '{32'h7FFF_FFFF, 32'h3FFF_FFFF, 1'b0, 3};
    vecs[9] = '{32'h8000_0001, 32'hBFFF_FFFF, 1'b0, 3};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_float", flt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      run_conv(vecs[i].fx, f, z, edges, bc);
      check($sformatf("vec%0d_float", i), f, vecs[i].fl);
      check($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].z));
      check($sformatf("vec%0d_lat", i), 32'(edges), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy", i), 32'(bc), 32'(vecs[i].lat));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_clr", i), 32'(done), 32'd0);
    end

    // Random operands spread across magnitudes
    for (int i = 0; i < 200; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      ref_model(v, rf, rl);
      run_conv(v, f, z, edges, bc);
      check($sformatf("rnd_float %h", v), f, rf);
      check($sformatf("rnd_lat %h", v), 32'(edges), 32'(rl));
      check($sformatf("rnd_zero %h", v), 32'(z), 32'(v == 0));
    end

    // Reset asserted mid-normalization aborts the conversion
    @(negedge clk);
    fixed = 32'h0000_0001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_float", flt, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    run_conv(32'h4000_0000, f, z, edges, bc);
    check("after_abort_float", f, 32'h3F80_0000);
    check("after_abort_lat", 32'(edges), 32'd3);

    // START pulsed while busy is ignored
    @(negedge clk);
    fixed = 32'h2000_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    fixed = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    f = '0;
    repeat (45) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        pulses++;
        f = flt;
      end
    end
    check("ignore_pulses", 32'(pulses), 32'd1);
    check("ignore_float", f, 32'h3F00_0000);
    check("ignore_idle", 32'(busy), 32'd0);

    // START held high: back-to-back conversions, FIXED changed while busy
    ops[0] = 32'h4000_0000;
    ops[1] = 32'hFFFF_FFFF;
    ops[2] = 32'h5555_5555;
    @(negedge clk);
    fixed = ops[0];
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("b2b%0d_busy", k), 32'(busy), 32'd1);
      fixed = (k < 2) ? ops[k+1] : $urandom;
      edges = 0;
      do begin
        @(posedge clk);
        #1;
        edges++;
      end while (done !== 1'b1 && edges < 40);
      if (k == 2) start = 1'b0;
      ref_model(ops[k], rf, rl);
      check($sformatf("b2b%0d_float", k), flt, rf);
      check($sformatf("b2b%0d_lat", k), 32'(edges), 32'(rl));
    end
    @(posedge clk);
    #1;
    check("b2b_done_clr", 32'(done), 32'd0);
    check("b2b_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fixed_to_float.md
Name: fixed_to_float

Overview:
- Sequential converter from 32-bit two's-complement fixed point to IEEE-754 single precision. It is the inverse path of the float-to-fixed converter.
- Fixed format matches the normalizer output: bit 31 is the sign, the binary point sits between bits 30 and 29, and FRAC=30 fraction bits give a range of [-2.0, 2.0).
- Normalization uses a one-bit-per-cycle left shift loop that decrements the exponent.
- Sits after the fixed-point datapath, returning results to the float domain; a controller drives it with a START/DONE handshake.

Parameters:
- P, 32, data width of the fixed input and the float output.
- FRAC, 30, fraction bits of the fixed input. Initial biased exponent is EXP_INIT = 127 + (P-1) - FRAC = 128.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous reset, active-low; clears all state while low.
- START  input  1  request; sampled only in IDLE.
- FIXED  input  32  fixed-point operand; captured on the edge where START is accepted.
- BUSY  output  1  high from the accept edge until the edge that raises DONE, inclusive.
- DONE  output  1  one-cycle pulse; FLOAT is valid in the same cycle.
- FLOAT  output  32  result {sign, exp[7:0], mant[22:0]}; holds its value until the next PACK.
- ZERO  output  1  registered with DONE; high when the input was 0.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE; BUSY=0, DONE=0, ZERO=0, FLOAT=0x00000000; internal magnitude, exponent and sign cleared. Assertion mid-conversion aborts it; no DONE is produced.
- States: IDLE, ABS, NORM, PACK.
- IDLE:
  - START=1 at an edge: capture FIXED into the operand register, BUSY<=1, go to ABS.
  - START=0: stay; DONE<=0.
- ABS (1 cycle):
  - SIGN<=FIXED[31].
  - MAG<=FIXED[31] ? (~FIXED+1) : FIXED, 32-bit unsigned.
  - 0x80000000 yields MAG=0x80000000 (treated as unsigned 2^31); no overflow.
  - EXP<=EXP_INIT (8-bit).
  - Next state: PACK if MAG==0 or MAG[31]==1, otherwise NORM. Decide from the computed value, not the stale register.
- NORM: each edge MAG<=MAG<<1 and EXP<=EXP-1. Leave for PACK on the edge where the shifted MAG[31] becomes 1.
  - n = 31 - (index of leading one), range 0..31.
  - EXP never underflows; minimum is 97.
- PACK (1 cycle): FLOAT<={SIGN, EXP, MAG[30:8]}, DONE<=1, BUSY<=0, go to IDLE.
  - Mantissa is truncated (round toward zero); MAG[7:0] is discarded.
  - Zero input: FLOAT<=0x00000000 (positive zero; sign forced to 0) and ZERO<=1; otherwise ZERO<=0.
- Latency (E0 = accept edge):
  - ABS at E1, NORM at E2..E(n+1), PACK at E(n+2).
  - DONE is high for the single cycle after E(n+2), then cleared at the next edge.
  - Maximum is 33 edges; zero input takes 2 edges.
- START while BUSY=1 is ignored, with no queuing. START held high continuously gives back-to-back conversions: the IDLE cycle after PACK accepts the next operand, and DONE and the new accept coincide.
- FIXED is sampled only at E0; later changes have no effect on the current conversion.
- No denormals, infinities or NaNs are ever produced; the output exponent is always in 97..128 or 0.

Test Plan:
- Reset mid-NORM: drive 0x00000001, assert RST low at E5 → BUSY=0, DONE never pulses, FLOAT=0x00000000, state=IDLE. A new START after release converts normally.
- Unity and half: 0x40000000 → FLOAT=0x3F800000 with DONE after E3 (n=1). 0x20000000 → 0x3F000000 (n=2).
- Sign and extreme: 0xC0000000 → 0xBF800000. 0x80000000 (-2.0) → 0xC0000000 with n=0 (DONE after E2).
- Smallest value: 0x00000001 → 0x30800000 with n=31; BUSY high for 33 cycles. 0xFFFFFFFF → 0xB0800000.
- Zero and truncation: 0x00000000 → FLOAT=0x00000000, ZERO=1, DONE after E2. 0x55555555 → 0x3FAAAAAA (truncated, not 0x3FAAAAAB).
- Handshake: pulse START during BUSY (ignored; one DONE only). Then hold START high for three operands → three DONE pulses with correct results, and the FIXED changes during BUSY do not corrupt them.
